// File: rtl/md5_block_padder.sv
// MD5 front end: packs a byte stream into 512-bit blocks and appends MD5 padding
// (0x80 marker, zero fill, 64-bit little-endian bit length).
module md5_block_padder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
);

    // Input handshake: a slot transfers on a rising edge where in_valid && in_ready.
    // Output handshake: a block transfers on a rising edge where blk_valid && blk_ready;
    // while blk_valid is high and blk_ready is low, blk_data and blk_last hold.
    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [511:0]   buf_q, buf_d;
    logic [6:0]     p_q, p_d;
    logic [60:0]    cnt_q, cnt_d;
    logic           pad_pending_q, pad_pending_d;
    logic           len_pending_q, len_pending_d;
    logic           last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            buf_q         <= '0;
            p_q           <= '0;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            len_pending_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            p_q           <= p_d;
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            len_pending_q <= len_pending_d;
            last_q        <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        p_d           = p_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        len_pending_d = len_pending_q;
        last_d        = last_q;

        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    if (in_keep) begin
                        buf_d[{p_q[5:0], 3'b000} +: 8] = in_data;
                        p_d   = p_q + 7'd1;
                        cnt_d = cnt_q + 61'd1;
                    end
                    // A full block goes out first; padding then restarts in a fresh block.
                    if (in_keep && (p_q == 7'd63)) begin
                        state_d       = S_OUT;
                        last_d        = 1'b0;
                        pad_pending_d = in_last;
                    end else if (in_last) begin
                        state_d = S_PAD;
                    end
                end
            end

            S_PAD: begin
                state_d = S_OUT;
                if (len_pending_q) begin
                    buf_d[448 +: 64] = {cnt_q, 3'b000};
                    len_pending_d    = 1'b0;
                    last_d           = 1'b1;
                end else if (p_q <= 7'd55) begin
                    buf_d[{p_q[5:0], 3'b000} +: 8] = 8'h80;
                    buf_d[448 +: 64]               = {cnt_q, 3'b000};
                    last_d                         = 1'b1;
                end else begin
                    // No room left for the length: it goes into a follow-on block.
                    buf_d[{p_q[5:0], 3'b000} +: 8] = 8'h80;
                    len_pending_d                  = 1'b1;
                    last_d                         = 1'b0;
                end
            end

            S_OUT: begin
                if (blk_ready) begin
                    buf_d  = '0;
                    p_d    = '0;
                    last_d = 1'b0;
                    if (pad_pending_q) begin
                        pad_pending_d = 1'b0;
                        state_d       = S_PAD;
                    end else if (len_pending_q) begin
                        state_d = S_PAD;
                    end else begin
                        if (last_q) begin
                            cnt_d = '0;
                        end
                        state_d = S_FILL;
                    end
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    assign in_ready  = (state_q == S_FILL);
    assign blk_valid = (state_q == S_OUT);
    assign blk_data  = buf_q;
    assign blk_last  = last_q;

endmodule
